// File: rtl/ddfs_note_seq_if.sv
// Note request handshake between a note source (UART/ROM player) and ddfs_note_seq.
// The source drives the master modport; the sequencer consumes the slave modport.
interface ddfs_note_seq_if #(
  parameter int PW = 30,
  parameter int DW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_fccw;
  logic [DW-1:0] s_dur;

  modport master (output s_valid, output s_fccw, output s_dur, input  s_ready);
  modport slave  (input  s_valid, input  s_fccw, input  s_dur, output s_ready);
endinterface

// File: rtl/ddfs_note_seq.sv
// Note sequencer and attack/sustain/release envelope controller feeding ddfs fccw/env.
// Optional abort input enabled by defining DDFS_NOTE_SEQ_ABORT_EN.
module ddfs_note_seq #(
  parameter int            PW      = 30,
  parameter int            EW      = 16,
  parameter int            DW      = 16,
  parameter logic [EW-1:0] ENV_MAX = 16'h4000,
  parameter int            DUR_DIV = 25000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  ddfs_note_seq_if.slave       s,
  input  logic [EW-1:0]        atk_step,
  input  logic [EW-1:0]        rel_step,
`ifdef DDFS_NOTE_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic [PW-1:0]        fccw,
  output logic [EW-1:0]        env,
  output logic                 busy,
  output logic                 note_done
);

  localparam int            PSW      = (DUR_DIV > 1) ? $clog2(DUR_DIV) : 1;
  localparam logic [PSW-1:0] PSC_LAST = PSW'(DUR_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  fccw_q, fccw_d;
  logic [EW-1:0]  env_q, env_d;
  logic [DW-1:0]  dur_q, dur_d;
  logic [PSW-1:0] psc_q, psc_d;
  logic [EW-1:0]  atk_q, atk_d;
  logic [EW-1:0]  rel_q, rel_d;
  logic           done_q, done_d;

  logic [EW:0]    atk_sum;
  logic           psc_wrap;
  logic           expiry;
  logic           abort_hit;

`ifdef DDFS_NOTE_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Attack sum is one bit wider so the clamp sees overflow instead of a wrapped value.
  assign atk_sum  = {1'b0, env_q} + {1'b0, atk_q};
  assign psc_wrap = (psc_q == PSC_LAST);
  assign expiry   = psc_wrap && (dur_q == DW'(1));

  always_comb begin
    state_d = state_q;
    fccw_d  = fccw_q;
    env_d   = env_q;
    dur_d   = dur_q;
    psc_d   = psc_q;
    atk_d   = atk_q;
    rel_d   = rel_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s.s_valid) begin
          fccw_d  = s.s_fccw;
          dur_d   = s.s_dur;
          atk_d   = atk_step;
          rel_d   = rel_step;
          psc_d   = '0;
          state_d = (s.s_dur == '0) ? RELEASE : ATTACK;
        end
      end

      ATTACK, SUSTAIN: begin
        if (abort_hit) begin
          state_d = RELEASE;
        end else if (en) begin
          psc_d = psc_wrap ? '0 : psc_q + 1'b1;
          if (psc_wrap) begin
            dur_d = dur_q - 1'b1;
          end
          // Expiry wins over both the attack step and the move to SUSTAIN.
          if (expiry) begin
            state_d = RELEASE;
          end else if (state_q == ATTACK) begin
            if ((atk_q == '0) || (atk_sum >= {1'b0, ENV_MAX})) begin
              env_d   = ENV_MAX;
              state_d = SUSTAIN;
            end else begin
              env_d = atk_sum[EW-1:0];
            end
          end
        end
      end

      RELEASE: begin
        if (en) begin
          if ((rel_q == '0) || (env_q <= rel_q)) begin
            env_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            env_d = env_q - rel_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fccw_q  <= '0;
      env_q   <= '0;
      dur_q   <= '0;
      psc_q   <= '0;
      atk_q   <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fccw_q  <= fccw_d;
      env_q   <= env_d;
      dur_q   <= dur_d;
      psc_q   <= psc_d;
      atk_q   <= atk_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
    end
  end

  assign s.s_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign fccw      = fccw_q;
  assign env       = env_q;
  assign note_done = done_q;

endmodule
